uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART serial receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line.
- Sits at the receive end of the team's UART link, opposite the transmitter that is paced by the baud generator.
- Uses its own bit-timing counter, restarted on each start edge, so sampling is aligned to mid-bit instead of a free-running tick.
- Delivers each received byte as a one-cycle valid pulse; reports framing errors separately.

Parameters:
- CLKS_PER_BIT, 2605, clock cycles per bit period; matches the 2605-cycle baud period at 50 MHz, ≈19200 baud.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; all state is cleared while rst=0.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  DATA_BITS  last correctly framed byte; holds its value until the next valid frame.
- valid  output  1  one-cycle pulse; data is updated in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: data=0, valid=0, frame_err=0, busy=0, state=IDLE, counter=0, bit index=0, both synchroniser flops=1.
- Input synchronisation: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- Counter: width $clog2(CLKS_PER_BIT); it never exceeds CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2 (integer division).
- IDLE:
  - rx_s=0 -> START, counter=0.
- START (counter increments each cycle):
  - At counter==HALF-1, sample rx_s.
  - rx_s=0 -> DATA, counter=0, bit index=0.
  - rx_s=1 -> IDLE (glitch or false start); no pulse is issued.
- DATA:
  - At counter==CLKS_PER_BIT-1: shift rx_s into the MSB of the shift register (right shift, so the first bit received ends up as LSB), counter=0, bit index++.
  - After bit index reaches DATA_BITS-1 and that bit is sampled -> STOP.
- STOP, at counter==CLKS_PER_BIT-1:
  - rx_s=1: data<=shift register, valid=1 for one cycle, -> IDLE.
  - rx_s=0: frame_err=1 for one cycle, data unchanged, -> WAIT_HIGH.
- WAIT_HIGH (break/line-low recovery):
  - Stay until rx_s=1, then -> IDLE. No start detection in this state.
- Timing: the stop sample occurs HALF + DATA_BITS*CLKS_PER_BIT + CLKS_PER_BIT cycles after the IDLE cycle that saw rx_s=0. valid/frame_err are registered and appear in the cycle after that sample.
- Back-to-back frames: IDLE is entered on the cycle after the stop sample, so a start edge arriving half a bit after the stop midpoint is accepted. No dead time beyond that one cycle.
- valid and frame_err are never high in the same cycle.
- Reset asserted mid-frame: everything returns immediately to reset values, and the partial byte is discarded.
- No back-pressure: the consumer must capture data on valid. The next valid may overwrite it no sooner than one frame time later.

Decomposition:
- uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, WAIT_HIGH};
  - default constants CLKS_PER_BIT_DEFAULT=2605 and DATA_BITS_DEFAULT=8;
  - a function computing HALF.
- Sub-module sync_2ff: 1-bit two-flop synchroniser with asynchronous active-low reset to a parameterised value (here 1). Reusable for other async inputs.
- The FSM, counter and shift register stay in uart_rx.

Test Plan (bench uses CLKS_PER_BIT=16, HALF=8; transmit model drives rx at 16 clk/bit):
- Frame 0xA5 (bits LSB first 1,0,1,0,0,1,0,1), stop=1 -> exactly one valid pulse, data=0xA5, frame_err never high, busy high from start detect until valid.
- Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses 160 cycles apart, data=0x00 then 0xFF.
- Low glitch of 3 cycles on idle line -> FSM returns to IDLE at the half-bit check; no valid, no frame_err; busy high for ≤9 cycles.
- Frame 0x3C with stop bit driven 0, then line held low 40 cycles -> one frame_err pulse, data keeps its previous value, no valid. FSM stays in WAIT_HIGH until rx returns high, then a following 0x81 frame is received correctly.
- rst pulsed low after the 4th data bit of 0x5A -> outputs at reset values during reset, no valid for the interrupted frame. A fresh 0x12 frame afterwards gives data=0x12.
- Receiver bit period 16, transmitter period 17 (≈6% slow), frame 0xC3 -> still received as data=0xC3 with valid, which confirms mid-bit sampling margin.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Imported by uart_rx; holds the FSM state type and the half-bit helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    // 2605 cycles per bit at 50 MHz gives about 19200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 2605;
    localparam int DATA_BITS_DEFAULT    = 8;

    // Mid-bit offset measured from the detected start edge.
    function automatic int half_period(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so idle-high lines do not glitch low out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line, mid-bit sampling.
// A bit-timing counter restarts on every start edge; bytes leave as one-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int HALF  = half_period(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // A start bit that is gone by mid-bit was a glitch; drop it silently.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // A held-low line must not be mistaken for a new start bit.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: a line-level transmit model predicts
// each frame's outcome and pulse cycle, and a per-cycle compare checks the outputs.
module tb_uart_rx;

    localparam int CPB      = 16;
    localparam int HALF     = CPB / 2;
    localparam int NBITS    = 8;
    localparam int STOP_OFS = HALF + NBITS * CPB + CPB;
    // Two synchroniser flops plus the IDLE cycle that notices the low line.
    localparam int DET_LAT  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int unsigned cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int unsigned at;
        bit          is_err;
        logic [7:0]  d;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;

    int          vcnt = 0;
    int          fcnt = 0;
    int          bcnt = 0;
    int unsigned last_vcyc = 0;
    logic [7:0]  last_vdata = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(NBITS)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Value on the wire o cycles after the start edge of a frame sent at the given bit period.
    function automatic bit line_val(input logic [7:0] d, input bit stop, input int period, input int o);
        int k;
        k = o / period;
        if (k == 0) return 1'b0;
        if (k <= NBITS) return d[k-1];
        if (k == NBITS + 1) return stop;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        bit exp_v;
        bit exp_f;
        exp_v = 1'b0;
        exp_f = 1'b0;
        if (!rst_n) begin
            model_data = 8'h00;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_event: cyc=%0d event due at %0d never matched", cyc, exp_q[0].at);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                exp_v = !exp_q[0].is_err;
                exp_f = exp_q[0].is_err;
                if (exp_v) model_data = exp_q[0].d;
                void'(exp_q.pop_front());
            end
        end
        tests++;
        if (valid !== exp_v || frame_err !== exp_f || data !== model_data) begin
            fails++;
            $display("FAIL cycle_compare cyc=%0d: got valid=%b frame_err=%b data=%02h, want valid=%b frame_err=%b data=%02h",
                     cyc, valid, frame_err, data, exp_v, exp_f, model_data);
        end
        if (valid === 1'b1) begin
            vcnt++;
            last_vcyc  = cyc;
            last_vdata = data;
        end
        if (frame_err === 1'b1) fcnt++;
        if (busy === 1'b1) bcnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    // Drive one frame; abort_at >= 0 stops driving at that offset (for mid-frame reset).
    task automatic send_frame(input logic [7:0] d, input bit stop, input int period,
                              input int tail_low, input int abort_at, output int unsigned start_cyc);
        ev_t        e;
        logic [7:0] bits;
        start_cyc = cyc;
        for (int j = 0; j < NBITS; j++) bits[j] = line_val(d, stop, period, HALF + (j + 1) * CPB);
        if (line_val(d, stop, period, HALF) == 1'b0) begin
            e.at     = start_cyc + DET_LAT + STOP_OFS;
            e.is_err = !line_val(d, stop, period, STOP_OFS);
            e.d      = bits;
            exp_q.push_back(e);
        end
        for (int o = 0; o < (NBITS + 2) * period; o++) begin
            if (o == abort_at) return;
            rx = line_val(d, stop, period, o);
            tick(1);
        end
        if (tail_low > 0) begin
            rx = 1'b0;
            tick(tail_low);
        end
        rx = 1'b1;
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        tick(len);
        rx = 1'b1;
    endtask

    initial begin
        int unsigned s0;
        int unsigned s1;
        int unsigned t0;
        logic [7:0]  d0;
        int          v0;
        int          f0;

        rst_n = 1'b0;
        rx    = 1'b1;
        tick(4);
        check("reset_data", data, 0);
        check("reset_valid", valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        idle(5);

        v0 = vcnt; f0 = fcnt; bcnt = 0;
        send_frame(8'hA5, 1'b1, CPB, 0, -1, s0);
        idle(10);
        check("a5_valid_count", vcnt - v0, 1);
        check("a5_data", last_vdata, 8'hA5);
        check("a5_valid_cycle", int'(last_vcyc - s0), 155);
        check("a5_no_frame_err", fcnt - f0, 0);
        check("a5_busy_cycles", bcnt, 152);

        v0 = vcnt;
        send_frame(8'h00, 1'b1, CPB, 0, -1, s0);
        t0 = last_vcyc;
        d0 = last_vdata;
        send_frame(8'hFF, 1'b1, CPB, 0, -1, s1);
        idle(10);
        check("b2b_valid_count", vcnt - v0, 2);
        check("b2b_first_data", d0, 8'h00);
        check("b2b_second_data", last_vdata, 8'hFF);
        check("b2b_spacing", int'(last_vcyc - t0), 160);

        v0 = vcnt; f0 = fcnt; bcnt = 0;
        glitch(3);
        idle(20);
        check("glitch_no_valid", vcnt - v0, 0);
        check("glitch_no_frame_err", fcnt - f0, 0);
        check("glitch_busy_cycles", bcnt, 8);

        v0 = vcnt; f0 = fcnt;
        send_frame(8'h3C, 1'b0, CPB, 40, -1, s0);
        idle(10);
        check("ferr_pulse_count", fcnt - f0, 1);
        check("ferr_no_valid", vcnt - v0, 0);
        check("ferr_data_kept", data, 8'hFF);
        send_frame(8'h81, 1'b1, CPB, 0, -1, s0);
        idle(10);
        check("after_ferr_data", data, 8'h81);
        check("after_ferr_valid_count", vcnt - v0, 1);

        v0 = vcnt;
        send_frame(8'h5A, 1'b1, CPB, 0, 5 * CPB, s0);
        rst_n = 1'b0;
        rx    = 1'b1;
        exp_q.delete();
        tick(3);
        check("midreset_data", data, 0);
        check("midreset_busy", busy, 0);
        rst_n = 1'b1;
        idle(200);
        check("midreset_no_valid", vcnt - v0, 0);
        send_frame(8'h12, 1'b1, CPB, 0, -1, s0);
        idle(10);
        check("post_reset_data", data, 8'h12);

        v0 = vcnt;
        send_frame(8'hC3, 1'b1, CPB + 1, 0, -1, s0);
        idle(5);
        check("slow_tx_valid_count", vcnt - v0, 1);
        check("slow_tx_data", last_vdata, 8'hC3);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] rd;
            bit         rs;
            int         gap;
            rd  = 8'($urandom_range(0, 255));
            rs  = ($urandom_range(0, 4) != 0);
            gap = int'($urandom_range(0, 10)) + (rs ? 0 : 2);
            send_frame(rd, rs, CPB, 0, -1, s0);
            idle(gap);
        end

        idle(20);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
